// File: rtl/sevseg_pkg.sv
// rtl/sevseg_pkg.sv - shared constants and state type for the seven-segment scan decoder
package sevseg_pkg;

    localparam int SEG_W = 7;

    // Active-low patterns, bit6=a ... bit0=g
    localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;
    localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
    localparam logic [SEG_W-1:0] SEG_B     = 7'b1100000;
    localparam logic [SEG_W-1:0] SEG_C     = 7'b0110001;
    localparam logic [SEG_W-1:0] SEG_D     = 7'b1000010;
    localparam logic [SEG_W-1:0] SEG_E     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_F     = 7'b0111000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        COLLECT = 1'b0,
        PUBLISH = 1'b1
    } state_t;

endpackage

// File: rtl/sevseg_pattern_decode.sv
// rtl/sevseg_pattern_decode.sv - combinational segment-pattern to value decoder
// Optional hex digits A..F enabled by SEVSEG_HEX_DECODE_EN.
module sevseg_pattern_decode
    import sevseg_pkg::*;
(
    input  logic [SEG_W-1:0] seg_n,
    output logic [3:0]       value,
    output logic             invalid
);

`ifdef SEVSEG_HEX_DECODE_EN
    localparam logic HEX_EN = 1'b1;
`else
    localparam logic HEX_EN = 1'b0;
`endif

    logic hex_hit;

    always_comb begin
        value   = 4'h0;
        invalid = 1'b0;
        hex_hit = 1'b0;
        case (seg_n)
            SEG_0: value = 4'h0;
            SEG_1: value = 4'h1;
            SEG_2: value = 4'h2;
            SEG_3: value = 4'h3;
            SEG_4: value = 4'h4;
            SEG_5: value = 4'h5;
            SEG_6: value = 4'h6;
            SEG_7: value = 4'h7;
            SEG_8: value = 4'h8;
            SEG_9: value = 4'h9;
            SEG_A: begin value = 4'hA; hex_hit = 1'b1; end
            SEG_B: begin value = 4'hB; hex_hit = 1'b1; end
            SEG_C: begin value = 4'hC; hex_hit = 1'b1; end
            SEG_D: begin value = 4'hD; hex_hit = 1'b1; end
            SEG_E: begin value = 4'hE; hex_hit = 1'b1; end
            SEG_F: begin value = 4'hF; hex_hit = 1'b1; end
            default: invalid = 1'b1;
        endcase
        // Hex letters fall back to the unrecognised encoding when disabled
        if (hex_hit && !HEX_EN) begin
            value   = 4'h0;
            invalid = 1'b1;
        end
    end

endmodule

// File: rtl/sevseg_scan_decoder.sv
// rtl/sevseg_scan_decoder.sv - recovers digit values from a multiplexed active-low seven-segment bus
// Hex letter decode is enabled by defining SEVSEG_HEX_DECODE_EN.
module sevseg_scan_decoder
    import sevseg_pkg::*;
#(
    parameter int NUM_DIGITS    = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [SEG_W-1:0]        seg_n,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   invalid_out,
    output logic                    frame_valid,
    output logic                    glitch
);

    localparam int              SAMPLE_W   = NUM_DIGITS + SEG_W;
    localparam logic [7:0]      STABLE_MAX = 8'(STABLE_CYCLES);
    localparam logic [NUM_DIGITS-1:0] ALL_SEEN = '1;

    state_t                    state_q, state_d;
    logic [7:0]                cnt_q, cnt_d;
    logic [SAMPLE_W-1:0]       prev_q, prev_d;
    logic [4*NUM_DIGITS-1:0]   shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0]     shadow_inv_q, shadow_inv_d;
    logic [NUM_DIGITS-1:0]     seen_q, seen_d;
    logic [4*NUM_DIGITS-1:0]   digits_q, digits_d;
    logic [NUM_DIGITS-1:0]     invalid_q, invalid_d;
    logic                      glitch_q, glitch_d;

    logic [SAMPLE_W-1:0]       sample;
    logic                      same;
    logic                      sel_onehot;
    logic                      sel_multi;
    logic                      latch;
    logic [NUM_DIGITS-1:0]     latch_mask;
    logic [3:0]                dec_value;
    logic                      dec_invalid;

    sevseg_pattern_decode u_decode (
        .seg_n   (seg_n),
        .value   (dec_value),
        .invalid (dec_invalid)
    );

    // Stability tracking and shadow capture
    always_comb begin
        sample       = {dig_sel, seg_n};
        same         = (sample == prev_q);
        sel_onehot   = $onehot(dig_sel);
        sel_multi    = ($countones(dig_sel) > 1);
        prev_d       = sample;
        glitch_d     = sel_multi;
        cnt_d        = 8'd0;
        if (sel_onehot) begin
            if (!same)
                cnt_d = 8'd1;
            else if (cnt_q >= STABLE_MAX)
                cnt_d = STABLE_MAX;
            else
                cnt_d = cnt_q + 8'd1;
        end
        // One latch per dwell: on reaching the threshold, or on a change when the threshold is 1
        latch        = sel_onehot && (cnt_d == STABLE_MAX) && ((cnt_q < STABLE_MAX) || !same);
        latch_mask   = latch ? dig_sel : '0;
        shadow_val_d = shadow_val_q;
        shadow_inv_d = shadow_inv_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (latch_mask[i]) begin
                shadow_val_d[4*i +: 4] = dec_value;
                shadow_inv_d[i]        = dec_invalid;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= COLLECT;
            cnt_q        <= 8'd0;
            prev_q       <= '0;
            shadow_val_q <= '0;
            shadow_inv_q <= '0;
            seen_q       <= '0;
            digits_q     <= '0;
            invalid_q    <= '0;
            glitch_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            prev_q       <= prev_d;
            shadow_val_q <= shadow_val_d;
            shadow_inv_q <= shadow_inv_d;
            seen_q       <= seen_d;
            digits_q     <= digits_d;
            invalid_q    <= invalid_d;
            glitch_q     <= glitch_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if ((seen_q | latch_mask) == ALL_SEEN) state_d = PUBLISH;
            PUBLISH: state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // Outputs are captured on entry to PUBLISH so they are visible alongside frame_valid
    always_comb begin
        frame_valid = (state_q == PUBLISH);
        seen_d      = (state_q == PUBLISH) ? latch_mask : (seen_q | latch_mask);
        digits_d    = digits_q;
        invalid_d   = invalid_q;
        if (state_q == COLLECT && state_d == PUBLISH) begin
            digits_d  = shadow_val_d;
            invalid_d = shadow_inv_d;
        end
    end

    assign digits_out  = digits_q;
    assign invalid_out = invalid_q;
    assign glitch      = glitch_q;

endmodule

// File: tb/tb_sevseg_scan_decoder.sv
// tb/tb_sevseg_scan_decoder.sv - scoreboard bench for sevseg_scan_decoder (NUM_DIGITS=2, STABLE_CYCLES=4)
module tb_sevseg_scan_decoder;

    logic       clock;
    logic       reset;
    logic [6:0] seg_n;
    logic [1:0] dig_sel;
    logic [7:0] digits_out;
    logic [1:0] invalid_out;
    logic       frame_valid;
    logic       glitch;

    localparam logic [6:0] P3     = 7'b0000110;
    localparam logic [6:0] P1     = 7'b1001111;
    localparam logic [6:0] P5     = 7'b0100100;
    localparam logic [6:0] P8     = 7'b0000000;
    localparam logic [6:0] PA     = 7'b0001000;
    localparam logic [6:0] PBLANK = 7'b1111111;

    int passed = 0;
    int total  = 0;
    int glitch_cnt = 0;
    logic [9:0] exp_q[$];

    sevseg_scan_decoder #(.NUM_DIGITS(2), .STABLE_CYCLES(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .seg_n       (seg_n),
        .dig_sel     (dig_sel),
        .digits_out  (digits_out),
        .invalid_out (invalid_out),
        .frame_valid (frame_valid),
        .glitch      (glitch)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every frame_valid pulse must match the oldest expected frame
    always @(negedge clock) begin
        if (!reset) begin
            if (glitch) glitch_cnt++;
            if (frame_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'(frame_valid), 32'd0);
                end else begin
                    logic [9:0] e;
                    e = exp_q.pop_front();
                    check("frame_digits", 32'(digits_out), 32'(e[9:2]));
                    check("frame_invalid", 32'(invalid_out), 32'(e[1:0]));
                end
            end
        end
    end

    task automatic drive(input logic [1:0] sel, input logic [6:0] seg, input int n);
        dig_sel = sel;
        seg_n   = seg;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        drive(2'b00, PBLANK, n);
    endtask

    initial begin
        int g0;
        reset   = 1'b1;
        dig_sel = 2'b01;
        seg_n   = P3;
        repeat (2) @(posedge clock);
        #1;
        check("reset_digits", 32'(digits_out), 32'd0);
        check("reset_invalid", 32'(invalid_out), 32'd0);
        check("reset_frame_valid", 32'(frame_valid), 32'd0);
        check("reset_glitch", 32'(glitch), 32'd0);
        reset   = 1'b0;
        dig_sel = 2'b00;
        repeat (3) begin
            @(negedge clock);
            check("no_frame_after_reset", 32'(frame_valid), 32'd0);
        end
        @(posedge clock);
        #1;

        // Basic frame: 3 then 1
        exp_q.push_back({8'h13, 2'b00});
        drive(2'b01, P3, 4);
        drive(2'b10, P1, 4);
        check("basic_latency", 32'(frame_valid), 32'd1);
        idle(4);
        check("basic_drained", 32'(exp_q.size()), 32'd0);

        // Multi-hot select, then a dwell one cycle short
        g0 = glitch_cnt;
        drive(2'b11, P8, 1);
        check("glitch_pulse", 32'(glitch), 32'd1);
        drive(2'b01, P3, 3);
        idle(4);
        check("glitch_count", 32'(glitch_cnt - g0), 32'd1);
        check("short_dwell_digits_held", 32'(digits_out), 32'h13);

        // Blank pattern is invalid
        exp_q.push_back({8'h03, 2'b10});
        drive(2'b01, P3, 4);
        drive(2'b10, PBLANK, 4);
        idle(3);
        check("invalid_drained", 32'(exp_q.size()), 32'd0);

        // Hex letter A on digit 0
`ifdef SEVSEG_HEX_DECODE_EN
        exp_q.push_back({8'h1A, 2'b00});
`else
        exp_q.push_back({8'h10, 2'b01});
`endif
        drive(2'b01, PA, 4);
        drive(2'b10, P1, 4);
        idle(3);
        check("hex_drained", 32'(exp_q.size()), 32'd0);

        // Long dwell latches once; a new pattern on the same digit overwrites the shadow
        exp_q.push_back({8'h15, 2'b00});
        drive(2'b01, P3, 10);
        drive(2'b01, P5, 4);
        drive(2'b10, P1, 4);
        idle(3);
        check("overwrite_drained", 32'(exp_q.size()), 32'd0);

        // Reset mid-frame discards digit 0
        drive(2'b01, P3, 4);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        drive(2'b10, P1, 4);
        idle(5);
        check("midreset_digits", 32'(digits_out), 32'd0);
        check("midreset_invalid", 32'(invalid_out), 32'd0);
        check("midreset_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sevseg_scan_decoder.md
Name: sevseg_scan_decoder

Overview:
- Receive-side counterpart of the team's binary-to-seven-segment encoder.
- Watches a time-multiplexed, active-low seven-segment bus (segment pattern plus one-hot digit select) and recovers the BCD value of each digit.
- Requires each digit's pattern to hold for a set number of cycles before accepting it; when every digit has been accepted, publishes one frame with a single-cycle valid pulse.
- Sits beside display drivers as a self-check and loopback monitor.

Parameters:
- NUM_DIGITS, 2, number of multiplexed digits (1..8).
- STABLE_CYCLES, 4, consecutive identical cycles needed to accept a digit (1..255).

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- seg_n  input  7  active-low segment pattern: bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
- dig_sel  input  NUM_DIGITS  one-hot, active-high digit select.
- digits_out  output  4*NUM_DIGITS  decoded values; digit i occupies bits [4i+3:4i].
- invalid_out  output  NUM_DIGITS  bit i set = digit i pattern not recognised.
- frame_valid  output  1  one-cycle pulse; digits_out and invalid_out update in the same cycle.
- glitch  output  1  one-cycle pulse, registered, when dig_sel has more than one bit set.

Behaviour:
- Reset (synchronous, active-high): all outputs 0, shadow registers 0, seen mask 0, stability counter 0, previous-sample registers 0, state COLLECT. Asserting reset mid-frame discards all partial captures.
- Decode table:
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4, 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9.
  - Any other pattern, including blank 1111111, → value 4'h0 with invalid set.
- Stability counter behaviour, evaluated each cycle:
  - dig_sel == 0: counter set to 0, no latch.
  - dig_sel multi-hot: counter set to 0, no latch, glitch=1 next cycle.
  - dig_sel one-hot and {dig_sel, seg_n} equal to the previous cycle's sample: counter increments, saturating at STABLE_CYCLES.
  - dig_sel one-hot and sample changed: counter set to 1.
- Latch event: the cycle in which the counter's next value equals STABLE_CYCLES and either the current value is below STABLE_CYCLES or the sample changed.
  - Exactly one latch per stable dwell.
  - With STABLE_CYCLES=1, latches occur only on change cycles.
- On a latch: decoded value and invalid bit written to shadow[i], and seen[i] set.
  - Re-latching an already-seen digit overwrites its shadow; the seen mask is unchanged.
- FSM states:
  - COLLECT: when (seen | latch bit) is all ones, move to PUBLISH.
  - PUBLISH: lasts exactly one cycle. digits_out and invalid_out take the shadow values, frame_valid=1, seen cleared, return to COLLECT.
  - A latch occurring during PUBLISH belongs to the next frame: clear first, then set that digit's bit.
- Latency: frame_valid is high in cycle N+1, where cycle N holds the completing latch.
- digits_out and invalid_out hold their values between frames.

Optional Feature:
- Macro: SEVSEG_HEX_DECODE_EN.
- Defined: additionally decodes 0001000→A, 1100000→b, 0110001→C, 1000010→d, 0110000→E, 0111000→F as valid values 4'hA..4'hF.
- Undefined: those six patterns are invalid (value 0, invalid bit set).

Decomposition:
- Shared package sevseg_pkg:
  - Pattern constants SEG_0..SEG_9, SEG_A..SEG_F, SEG_BLANK.
  - Width constant SEG_W=7.
  - State enum {COLLECT, PUBLISH}.
- Sub-module sevseg_pattern_decode: combinational, 7-bit pattern in, {invalid, 4-bit value} out; the macro is honoured here only.

Test Plan (NUM_DIGITS=2, STABLE_CYCLES=4):
- Reset: reset=1 for 2 cycles while driving valid dwells → all outputs 0; no frame_valid within 3 cycles after release.
- Basic frame:
  - Stimulus: dig_sel=01, seg_n=0000110 for 4 cycles; then dig_sel=10, seg_n=1001111 for 4 cycles.
  - Response: frame_valid=1 for exactly one cycle, on the cycle after the 8th; digits_out=8'h13, invalid_out=2'b00.
- Glitch and instability: dig_sel=11 for 1 cycle → glitch pulse next cycle. Then digit0 dwell of only 3 cycles before changing → no latch and no frame_valid.
- Invalid pattern: digit0 = 3 stable, digit1 = 1111111 stable → frame_valid with digits_out=8'h03, invalid_out=2'b10.
- Hex macro: digit0 = 0001000, digit1 = 1001111.
  - With macro: digits_out=8'h1A, invalid_out=00.
  - Without macro: digits_out=8'h10, invalid_out=01.
- Reset mid-frame: latch digit0, pulse reset, then latch digit1 only → no frame_valid; digits_out stays 0.
